// File: rtl/data_bus_resp_pkg.sv
// data_bus_resp_pkg
//   Shared constants for the data-bus responder: I/O register byte offsets
//   within the I/O block, TCTRL / IPEND bit positions and the default I/O
//   block base address.
package data_bus_resp_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h8000_0000;

  // Byte offsets inside the 32-byte I/O window (bits [4:0] of the address)
  localparam logic [4:0] OFF_LED    = 5'h00;
  localparam logic [4:0] OFF_SW     = 5'h04;
  localparam logic [4:0] OFF_TCOUNT = 5'h08;
  localparam logic [4:0] OFF_TCMP   = 5'h0C;
  localparam logic [4:0] OFF_TCTRL  = 5'h10;
  localparam logic [4:0] OFF_IPEND  = 5'h14;

  // TCTRL bits
  localparam int TCTRL_EN = 0;
  localparam int TCTRL_AR = 1;

  // IPEND bits
  localparam int IPEND_TMR = 0;
  localparam int IPEND_SW  = 1;
  localparam int IPEND_CP0 = 2;

endpackage

// File: rtl/data_bus_resp_timer.sv
// dbr_timer
//   Free-running compare timer: TCOUNT, TCMP, TCTRL and the match detect.
//   Ports:
//     clk, rst           clock, synchronous active-low reset
//     i_wr_count/cmp/ctrl  CPU write strobes for the three registers
//     i_wdata            CPU write data
//     o_count/o_cmp/o_ctrl register values for read-back
//     o_match            enabled and TCOUNT==TCMP this cycle
module dbr_timer
  import data_bus_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_count,
  input  logic        i_wr_cmp,
  input  logic        i_wr_ctrl,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_cmp,
  output logic [1:0]  o_ctrl,
  output logic        o_match
);

  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic [1:0]  r_ctrl;
  logic        w_match;

  assign w_match = r_ctrl[TCTRL_EN] && (r_count == r_cmp);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
      r_cmp   <= '0;
      r_ctrl  <= '0;
    end else begin
      if (i_wr_cmp)  r_cmp  <= i_wdata;
      if (i_wr_ctrl) r_ctrl <= i_wdata[1:0];
      // CPU write beats both reload and increment
      if (i_wr_count)
        r_count <= i_wdata;
      else if (r_ctrl[TCTRL_EN]) begin
        if (w_match && r_ctrl[TCTRL_AR])
          r_count <= '0;
        else
          r_count <= r_count + 32'd1;
      end
    end
  end

  assign o_count = r_count;
  assign o_cmp   = r_cmp;
  assign o_ctrl  = r_ctrl;
  assign o_match = w_match;

endmodule

// File: rtl/data_bus_resp.sv
// data_bus_resp
//   CPU data-bus responder: word RAM at address 0, a small I/O register block
//   at IO_BASE (LED, SW, timer, interrupt pending) and interrupt lines.
//   Optional feature macro: DATA_BUS_RESP_SWITCH_EN enables the switch
//   synchronizer, SW read-back and the switch-change interrupt (IPEND[1]).
//   Ports:
//     clk, rst          clock, synchronous active-low reset
//     memCe, memWr      access enable, 1=write
//     memAddr, wtData   byte address (word aligned use), write data
//     rdData            combinational read data
//     intimer           CP0 timer pulse -> IPEND[2]
//     intr[5:0]         {3'b0, IPEND}
//     sw, led           board switches / LEDs
module data_bus_resp
  import data_bus_resp_pkg::*;
#(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memCe,
  input  logic        memWr,
  input  logic [31:0] memAddr,
  input  logic [31:0] wtData,
  output logic [31:0] rdData,
  input  logic        intimer,
  output logic [5:0]  intr,
  input  logic [15:0] sw,
  output logic [15:0] led
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

  // ---------------- decode ----------------
  logic       w_ram_sel, w_io_sel, w_wr;
  logic [4:0] w_off;
  logic       w_wr_led, w_wr_count, w_wr_cmp, w_wr_ctrl, w_wr_ipend;

  assign w_ram_sel  = memAddr < RAM_BYTES;
  assign w_io_sel   = memAddr[31:5] == IO_BASE[31:5];
  assign w_wr       = memCe && memWr;
  assign w_off      = {memAddr[4:2], 2'b00};
  assign w_wr_led   = w_wr && w_io_sel && (w_off == OFF_LED);
  assign w_wr_count = w_wr && w_io_sel && (w_off == OFF_TCOUNT);
  assign w_wr_cmp   = w_wr && w_io_sel && (w_off == OFF_TCMP);
  assign w_wr_ctrl  = w_wr && w_io_sel && (w_off == OFF_TCTRL);
  assign w_wr_ipend = w_wr && w_io_sel && (w_off == OFF_IPEND);

  // ---------------- RAM (not reset) ----------------
  logic [31:0] r_ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (w_wr && w_ram_sel) r_ram[memAddr[AW+1:2]] <= wtData;
  end

  // ---------------- LED ----------------
  logic [15:0] r_led;

  always_ff @(posedge clk) begin
    if (!rst)          r_led <= '0;
    else if (w_wr_led) r_led <= wtData[15:0];
  end

  assign led = r_led;

  // ---------------- timer ----------------
  logic [31:0] w_tcount, w_tcmp;
  logic [1:0]  w_tctrl;
  logic        w_tmr_match;

  dbr_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_wr_count (w_wr_count),
    .i_wr_cmp   (w_wr_cmp),
    .i_wr_ctrl  (w_wr_ctrl),
    .i_wdata    (wtData),
    .o_count    (w_tcount),
    .o_cmp      (w_tcmp),
    .o_ctrl     (w_tctrl),
    .o_match    (w_tmr_match)
  );

  // ---------------- switches ----------------
  logic        w_sw_chg;
  logic [31:0] w_sw_rd;

`ifdef DATA_BUS_RESP_SWITCH_EN
  logic [15:0] r_sw_meta, r_sw_sync, r_sw_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_sw_prev <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      r_sw_prev <= r_sw_sync;
    end
  end

  assign w_sw_chg = r_sw_sync != r_sw_prev;
  assign w_sw_rd  = {16'b0, r_sw_sync};
`else
  assign w_sw_chg = 1'b0;
  assign w_sw_rd  = '0;
`endif

  // ---------------- IPEND ----------------
  logic [2:0] r_ipend, w_ipend_set, w_ipend_nxt;

  always_comb begin
    w_ipend_set            = '0;
    w_ipend_set[IPEND_TMR] = w_tmr_match;
    w_ipend_set[IPEND_SW]  = w_sw_chg;
    w_ipend_set[IPEND_CP0] = intimer;
    w_ipend_nxt            = r_ipend;
    if (w_wr_ipend) w_ipend_nxt = w_ipend_nxt & ~wtData[2:0];
    // set applied after clear so a coincident hardware event wins
    w_ipend_nxt = w_ipend_nxt | w_ipend_set;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_ipend <= '0;
    else      r_ipend <= w_ipend_nxt;
  end

  assign intr = {3'b000, r_ipend};

  // ---------------- read mux ----------------
  // Driven whenever memCe=1, so a write cycle shows the pre-write value.
  always_comb begin
    rdData = '0;
    if (memCe) begin
      if (w_ram_sel)
        rdData = r_ram[memAddr[AW+1:2]];
      else if (w_io_sel) begin
        case (w_off)
          OFF_LED:    rdData = {16'b0, r_led};
          OFF_SW:     rdData = w_sw_rd;
          OFF_TCOUNT: rdData = w_tcount;
          OFF_TCMP:   rdData = w_tcmp;
          OFF_TCTRL:  rdData = {30'b0, w_tctrl};
          OFF_IPEND:  rdData = {29'b0, r_ipend};
          default:    rdData = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_bus_resp.sv
module tb_data_bus_resp;

  localparam logic [31:0] IOB     = 32'h8000_0000;
  localparam logic [31:0] A_LED   = IOB + 32'h00;
  localparam logic [31:0] A_SW    = IOB + 32'h04;
  localparam logic [31:0] A_TCNT  = IOB + 32'h08;
  localparam logic [31:0] A_TCMP  = IOB + 32'h0C;
  localparam logic [31:0] A_TCTRL = IOB + 32'h10;
  localparam logic [31:0] A_IPEND = IOB + 32'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memCe = 1'b0, memWr = 1'b0;
  logic [31:0] memAddr = '0, wtData = '0;
  logic [31:0] rdData;
  logic        intimer = 1'b0;
  logic [5:0]  intr;
  logic [15:0] sw = '0;
  logic [15:0] led;

  int checks = 0;
  int errors = 0;

  data_bus_resp dut (
    .clk(clk), .rst(rst), .memCe(memCe), .memWr(memWr), .memAddr(memAddr),
    .wtData(wtData), .rdData(rdData), .intimer(intimer), .intr(intr),
    .sw(sw), .led(led)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memCe = 1'b1; memWr = 1'b1; memAddr = a; wtData = d;
    tick();
    memCe = 1'b0; memWr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    memCe = 1'b1; memWr = 1'b0; memAddr = a;
    #1 d = rdData;
    memCe = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0;
    tick(); tick();
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led got %h exp 0000", led); end
    checks++; if (intr !== 6'h0) begin errors++; $display("FAIL reset_intr got %h exp 00", intr); end
    rd(A_TCTRL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_tctrl got %h exp 0", d); end
    memAddr = 32'h10; memCe = 1'b0; #1;
    checks++; if (rdData !== 32'h0) begin errors++; $display("FAIL ce0_read got %h exp 0", rdData); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ram();
    logic [31:0] d;
    wr(32'h10, 32'h1234_5678);
    rd(32'h10, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL ram_rd got %h exp 12345678", d); end
    rd(32'h400, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_rd got %h exp 0", d); end
    wr(32'h3FC, 32'h0BAD_F00D);
    rd(32'h3FC, d);
    checks++; if (d !== 32'h0BAD_F00D) begin errors++; $display("FAIL ram_last got %h exp 0badf00d", d); end
    // write in progress shows old value until the edge
    memCe = 1'b1; memWr = 1'b1; memAddr = 32'h10; wtData = 32'hDEAD_BEEF; #1;
    checks++; if (rdData !== 32'h1234_5678) begin errors++; $display("FAIL rd_old got %h exp 12345678", rdData); end
    tick();
    memCe = 1'b0; memWr = 1'b0;
    rd(32'h10, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_new got %h exp deadbeef", d); end
  endtask

  task automatic test_led_sw();
    logic [31:0] d;
    wr(A_LED, 32'hFFFF_A5A5);
    checks++; if (led !== 16'hA5A5) begin errors++; $display("FAIL led_out got %h exp a5a5", led); end
    rd(A_LED, d);
    checks++; if (d !== 32'h0000_A5A5) begin errors++; $display("FAIL led_rd got %h exp 0000a5a5", d); end
    wr(A_SW, 32'hFFFF_FFFF);
    rd(A_SW, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL sw_ro got %h exp 0", d); end
  endtask

  task automatic test_timer_reload();
    logic [31:0] d;
    wr(A_TCMP, 32'd5);
    wr(A_TCTRL, 32'd3);
    repeat (5) tick();
    rd(A_TCNT, d);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL tcnt_pre got %h exp 5", d); end
    checks++; if (intr[0] !== 1'b0) begin errors++; $display("FAIL intr0_pre got %b exp 0", intr[0]); end
    tick();
    checks++; if (intr[0] !== 1'b1) begin errors++; $display("FAIL intr0_match got %b exp 1", intr[0]); end
    rd(A_TCNT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL tcnt_reload got %h exp 0", d); end
    wr(A_IPEND, 32'h1);
    checks++; if (intr[0] !== 1'b0) begin errors++; $display("FAIL w1c_tmr got %b exp 0", intr[0]); end
    repeat (4) tick();
    checks++; if (intr[0] !== 1'b0) begin errors++; $display("FAIL intr0_wait got %b exp 0", intr[0]); end
    tick();
    checks++; if (intr[0] !== 1'b1) begin errors++; $display("FAIL intr0_rematch got %b exp 1", intr[0]); end
    tick();
    checks++; if (intr[0] !== 1'b1) begin errors++; $display("FAIL intr0_hold got %b exp 1", intr[0]); end
    wr(A_TCNT, 32'd100);
    rd(A_TCNT, d);
    checks++; if (d !== 32'd100) begin errors++; $display("FAIL tcnt_wr_prio got %h exp 64", d); end
    wr(A_TCTRL, 32'd0);
    wr(A_IPEND, 32'h7);
  endtask

  task automatic test_timer_wrap();
    logic [31:0] d;
    wr(A_TCMP, 32'hFFFF_FFFF);
    wr(A_TCNT, 32'hFFFF_FFFE);
    wr(A_TCTRL, 32'd1);
    rd(A_TCNT, d);
    checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_start got %h exp fffffffe", d); end
    tick();
    rd(A_TCNT, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_max got %h exp ffffffff", d); end
    checks++; if (intr[0] !== 1'b0) begin errors++; $display("FAIL wrap_intr_pre got %b exp 0", intr[0]); end
    tick();
    checks++; if (intr[0] !== 1'b1) begin errors++; $display("FAIL wrap_intr got %b exp 1", intr[0]); end
    rd(A_TCNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp 0", d); end
    wr(A_TCTRL, 32'd0);
    wr(A_IPEND, 32'h7);
  endtask

  task automatic test_intimer_w1c();
    logic [31:0] d;
    intimer = 1'b1;
    memCe = 1'b1; memWr = 1'b1; memAddr = A_IPEND; wtData = 32'h4;
    tick();
    intimer = 1'b0; memCe = 1'b0; memWr = 1'b0;
    checks++; if (intr[2] !== 1'b1) begin errors++; $display("FAIL set_wins got %b exp 1", intr[2]); end
    rd(A_IPEND, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL ipend_rd got %h exp 4", d); end
    wr(A_IPEND, 32'h4);
    checks++; if (intr !== 6'h0) begin errors++; $display("FAIL w1c_cp0 got %h exp 00", intr); end
  endtask

  task automatic test_switch();
    logic [31:0] d;
    sw = 16'h0003;
`ifdef DATA_BUS_RESP_SWITCH_EN
    tick();
    rd(A_SW, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL sw_sync1 got %h exp 0", d); end
    tick();
    rd(A_SW, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL sw_sync2 got %h exp 3", d); end
    tick();
    checks++; if (intr[1] !== 1'b1) begin errors++; $display("FAIL sw_intr got %b exp 1", intr[1]); end
    wr(A_IPEND, 32'h2);
    checks++; if (intr[1] !== 1'b0) begin errors++; $display("FAIL sw_w1c got %b exp 0", intr[1]); end
`else
    repeat (4) tick();
    rd(A_SW, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL sw_off_rd got %h exp 0", d); end
    checks++; if (intr[1] !== 1'b0) begin errors++; $display("FAIL sw_off_intr got %b exp 0", intr[1]); end
`endif
    sw = 16'h0000;
    repeat (4) tick();
    wr(A_IPEND, 32'h7);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(A_LED, 32'h0000_A5A5);
    wr(32'h20, 32'hCAFE_F00D);
    wr(A_TCMP, 32'd3);
    wr(A_TCTRL, 32'd1);
    intimer = 1'b1;
    tick();
    intimer = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL rst_led got %h exp 0000", led); end
    checks++; if (intr !== 6'h0) begin errors++; $display("FAIL rst_intr got %h exp 00", intr); end
    repeat (8) tick();
    checks++; if (intr !== 6'h0) begin errors++; $display("FAIL rst_no_irq got %h exp 00", intr); end
    rd(A_TCNT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_tcnt got %h exp 0", d); end
    rd(32'h20, d);
    checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_keep got %h exp cafef00d", d); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led_sw();
    test_timer_reload();
    test_timer_wrap();
    test_intimer_w1c();
    test_switch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
